// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready handshake and full backpressure.
// The carry-in rides as an extra prefix element below bit 0, so carries come out of the tree directly.
module prefix_adder_pipe #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned PIPE_EVERY = 1,
    parameter int unsigned TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned NSTG   = (LEVELS + PIPE_EVERY - 1) / PIPE_EVERY;
    localparam int unsigned N      = WIDTH + 1;

    // Apply the prefix levels [first, first+PIPE_EVERY) of the tree; returns {g, p}.
    function automatic logic [2*N-1:0] ks_levels(input logic [N-1:0] g_in,
                                                 input logic [N-1:0] p_in,
                                                 input int unsigned  first);
        logic [N-1:0] g;
        logic [N-1:0] p;
        logic [N-1:0] g_nx;
        logic [N-1:0] p_nx;
        g = g_in;
        p = p_in;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            if (l >= first && l < first + PIPE_EVERY) begin
                g_nx = g;
                p_nx = p;
                for (int unsigned j = (32'd1 << l); j < N; j++) begin
                    g_nx[j] = g[j] | (p[j] & g[j - (32'd1 << l)]);
                    p_nx[j] = p[j] & p[j - (32'd1 << l)];
                end
                g = g_nx;
                p = p_nx;
            end
        end
        return {g, p};
    endfunction

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    logic [N-1:0]     stg_g   [NSTG];
    logic [N-1:0]     stg_p   [NSTG];
    logic [WIDTH-1:0] stg_pp  [NSTG];
    logic [TAG_W-1:0] stg_tag [NSTG];
    logic [NSTG-1:0]  stg_v;

    logic [N-1:0]     nx_g [NSTG];
    logic [N-1:0]     nx_p [NSTG];
    logic [N-1:0]     g_all;
    logic [WIDTH-1:0] sum_nx;
    logic             cout_nx;
    logic             ovf_nx;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign b_eff    = in_sub ? ~in_b : in_b;
    assign c0       = in_sub | in_cin;

    // Prefix levels owned by each stage, evaluated on that stage's register contents.
    always_comb begin
        for (int unsigned s = 0; s < NSTG; s++) begin
            {nx_g[s], nx_p[s]} = ks_levels(stg_g[s], stg_p[s], s * PIPE_EVERY);
        end
    end

    // Top element spans bits W-1..0 only; one more combine pulls in the carry-in at element 0.
    always_comb begin
        g_all   = nx_g[NSTG-1] | (nx_p[NSTG-1] & {N{nx_g[NSTG-1][0]}});
        sum_nx  = stg_pp[NSTG-1] ^ g_all[WIDTH-1:0];
        cout_nx = g_all[WIDTH];
        ovf_nx  = g_all[WIDTH-1] ^ g_all[WIDTH];
    end

    // Datapath registers: no reset needed, validity is tracked separately.
    always_ff @(posedge clk) begin
        if (!stall) begin
            stg_g[0]   <= {in_a & b_eff, c0};
            stg_p[0]   <= {in_a ^ b_eff, 1'b0};
            stg_pp[0]  <= in_a ^ b_eff;
            stg_tag[0] <= in_tag;
            for (int unsigned s = 1; s < NSTG; s++) begin
                stg_g[s]   <= nx_g[s-1];
                stg_p[s]   <= nx_p[s-1];
                stg_pp[s]  <= stg_pp[s-1];
                stg_tag[s] <= stg_tag[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_v     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_tag   <= '0;
        end else if (!stall) begin
            stg_v[0] <= in_valid;
            for (int unsigned s = 1; s < NSTG; s++) begin
                stg_v[s] <= stg_v[s-1];
            end
            out_valid <= stg_v[NSTG-1];
            out_sum   <= sum_nx;
            out_cout  <= cout_nx;
            out_ovf   <= ovf_nx;
            out_tag   <= stg_tag[NSTG-1];
        end
    end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Directed and randomized checks of prefix_adder_pipe at WIDTH=32, PIPE_EVERY=1 (latency 6).
module tb_prefix_adder_pipe;

    localparam int unsigned W     = 32;
    localparam int unsigned PE    = 1;
    localparam int unsigned TW    = 4;
    localparam int          LAT   = 6;
    localparam int          NRAND = 300;

    typedef struct packed {
        logic [W-1:0]  sum;
        logic          co;
        logic          ov;
        logic [TW-1:0] tag;
    } res_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic          in_sub;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic [TW-1:0] out_tag;

    int errors = 0;
    int checks = 0;

    prefix_adder_pipe #(.WIDTH(W), .PIPE_EVERY(PE), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain wide addition, carry into MSB from a separate (W-1)-bit sum.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub, input logic [TW-1:0] tag);
        res_t          r;
        logic [W-1:0]  bp;
        logic          c;
        logic [W:0]    full;
        logic [W-1:0]  low;
        bp    = sub ? ~b : b;
        c     = sub | cin;
        full  = {1'b0, a} + {1'b0, bp} + (W+1)'(c);
        low   = {1'b0, a[W-2:0]} + {1'b0, bp[W-2:0]} + W'(c);
        r.sum = full[W-1:0];
        r.co  = full[W];
        r.ov  = low[W-1] ^ full[W];
        r.tag = tag;
        return r;
    endfunction

    // Issue one beat into an idle pipe and wait (bounded) for its result.
    task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input logic sub, input logic [TW-1:0] tag, output int lat, output res_t r);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_tag = tag;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        r.sum = out_sum; r.co = out_cout; r.ov = out_ovf; r.tag = out_tag;
        step();
    endtask

    task automatic test_reset();
        bit seen;
        rst = 1'b1; in_valid = 1'b1; in_a = 32'h1; in_b = 32'h1; out_ready = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++;
        if (out_sum !== '0 || out_cout !== 1'b0 || out_ovf !== 1'b0 || out_tag !== '0) begin
            errors++;
            $display("FAIL reset_outputs: sum=%h cout=%b ovf=%b tag=%h want all 0", out_sum, out_cout, out_ovf, out_tag);
        end
        rst = 1'b0; in_valid = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen = 1;
            step();
        end
        checks++;
        if (seen) begin errors++; $display("FAIL reset_no_emit: got out_valid=1 want none"); end
    endtask

    task automatic check_res(input string name, input int lat, input res_t r, input res_t e);
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, lat, LAT); end
        checks++;
        if (r !== e) begin
            errors++;
            $display("FAIL %s_result: got sum=%h cout=%b ovf=%b tag=%h want sum=%h cout=%b ovf=%b tag=%h",
                     name, r.sum, r.co, r.ov, r.tag, e.sum, e.co, e.ov, e.tag);
        end
    endtask

    task automatic test_add();
        int   lat;
        res_t r;
        send_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 4'h3, lat, r);
        check_res("add_ovf", lat, r, '{sum: 32'h8000_0000, co: 1'b0, ov: 1'b1, tag: 4'h3});
        send_one(32'h10, 32'h20, 1'b1, 1'b0, 4'hA, lat, r);
        check_res("add_cin", lat, r, '{sum: 32'h31, co: 1'b0, ov: 1'b0, tag: 4'hA});
    endtask

    task automatic test_sub();
        int   lat;
        res_t r;
        send_one(32'd5, 32'd7, 1'b0, 1'b1, 4'h1, lat, r);
        check_res("sub_neg", lat, r, '{sum: 32'hFFFF_FFFE, co: 1'b0, ov: 1'b0, tag: 4'h1});
        send_one(32'd7, 32'd5, 1'b0, 1'b1, 4'h2, lat, r);
        check_res("sub_pos", lat, r, '{sum: 32'h2, co: 1'b1, ov: 1'b0, tag: 4'h2});
        send_one(32'd5, 32'd7, 1'b1, 1'b1, 4'h4, lat, r);
        check_res("sub_cin_ignored", lat, r, '{sum: 32'hFFFF_FFFE, co: 1'b0, ov: 1'b0, tag: 4'h4});
    endtask

    task automatic test_wrap();
        int   lat;
        res_t r;
        send_one(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'h5, lat, r);
        check_res("wrap_ones", lat, r, '{sum: 32'h0, co: 1'b1, ov: 1'b0, tag: 4'h5});
        send_one(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 4'h6, lat, r);
        check_res("wrap_negovf", lat, r, '{sum: 32'h0, co: 1'b1, ov: 1'b1, tag: 4'h6});
        send_one(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 4'hF, lat, r);
        check_res("wrap_cin", lat, r, '{sum: 32'h0, co: 1'b1, ov: 1'b0, tag: 4'hF});
    endtask

    task automatic test_backpressure();
        int   sent = 0;
        int   got = 0;
        int   cyc = 0;
        logic stalled = 1'b0;
        res_t held;
        res_t cur;
        while (got < 20 && cyc < 400) begin
            @(posedge clk);
            #1;
            out_ready = ((cyc / 3) % 2) == 1;
            in_valid  = sent < 20;
            in_a = W'(sent); in_b = W'(sent); in_tag = TW'(sent); in_cin = 1'b0; in_sub = 1'b0;
            #1;
            cur = '{sum: out_sum, co: out_cout, ov: out_ovf, tag: out_tag};
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || cur !== held) begin
                    errors++;
                    $display("FAIL bp_hold: got valid=%b sum=%h tag=%h want valid=1 sum=%h tag=%h",
                             out_valid, cur.sum, cur.tag, held.sum, held.tag);
                end
            end
            stalled = out_valid && !out_ready;
            held = cur;
            if (out_valid && out_ready) begin
                checks++;
                if (cur !== '{sum: W'(2 * got), co: 1'b0, ov: 1'b0, tag: TW'(got)}) begin
                    errors++;
                    $display("FAIL bp_result: beat %0d got sum=%h tag=%h want sum=%h tag=%h",
                             got, cur.sum, cur.tag, W'(2 * got), TW'(got));
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        checks++;
        if (got != 20) begin errors++; $display("FAIL bp_timeout: got %0d results want 20", got); end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset_midflight();
        bit   seen = 0;
        int   lat;
        res_t r;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_a = W'(100 + i); in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_tag = TW'(i);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen = 1;
            step();
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midrst_discard: got out_valid=1 want none"); end
        send_one(32'h1234, 32'h1111, 1'b0, 1'b0, 4'h9, lat, r);
        check_res("midrst_next", lat, r, '{sum: 32'h2345, co: 1'b0, ov: 1'b0, tag: 4'h9});
    endtask

    task automatic test_random();
        res_t q[$];
        res_t cur;
        res_t held;
        res_t exp_r;
        logic pend = 1'b0;
        logic stalled = 1'b0;
        int   sent = 0;
        int   got = 0;
        int   cyc = 0;
        while (got < NRAND && cyc < 5000) begin
            @(posedge clk);
            #1;
            out_ready = $urandom_range(0, 3) != 0;
            if (!pend && sent < NRAND && $urandom_range(0, 4) != 0) begin
                in_a = $urandom; in_b = $urandom;
                in_cin = 1'($urandom_range(0, 1)); in_sub = 1'($urandom_range(0, 1));
                in_tag = TW'($urandom_range(0, 15));
                pend = 1'b1;
            end
            in_valid = pend;
            #1;
            cur = '{sum: out_sum, co: out_cout, ov: out_ovf, tag: out_tag};
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || cur !== held) begin
                    errors++;
                    $display("FAIL rnd_hold: got valid=%b sum=%h want valid=1 sum=%h", out_valid, cur.sum, held.sum);
                end
            end
            stalled = out_valid && !out_ready;
            held = cur;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra: got sum=%h want no result", cur.sum);
                end else begin
                    exp_r = q.pop_front();
                    if (cur !== exp_r) begin
                        errors++;
                        $display("FAIL rnd_result: beat %0d got sum=%h cout=%b ovf=%b tag=%h want sum=%h cout=%b ovf=%b tag=%h",
                                 got, cur.sum, cur.co, cur.ov, cur.tag, exp_r.sum, exp_r.co, exp_r.ov, exp_r.tag);
                    end
                end
                got++;
            end
            if (pend && in_ready) begin
                q.push_back(model(in_a, in_b, in_cin, in_sub, in_tag));
                sent++;
                pend = 1'b0;
            end
            cyc++;
        end
        checks++;
        if (got != NRAND) begin errors++; $display("FAIL rnd_timeout: got %0d results want %0d", got, NRAND); end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        in_tag = '0; out_ready = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_wrap();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
